// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M div/divu/rem/remu.
// Accepts operands on start_i while idle (or in the result cycle) and pulses valid_o with the result.
module seq_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [W-1:0]     ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0]     ZERO     = {W{1'b0}};
    localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic [W-1:0] negate(input logic [W-1:0] v);
        negate = ~v + {{(W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic signed_op);
        if (signed_op && v[W-1]) begin
            magnitude = negate(v);
        end else begin
            magnitude = v;
        end
    endfunction

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [W-1:0]       res_q, res_d;
    logic               rem_sel_q, rem_sel_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       dvs_q, dvs_d;
    logic [W:0]         rem_q, rem_d;
    logic [W-1:0]       quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;

    logic               accept_s;
    logic               signed_in_s;
    logic [W:0]         shifted_s;
    logic [W+1:0]       trial_s;
    logic               keep_s;

    // A request is taken whenever the block is not busy, including the DONE cycle.
    assign accept_s    = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign signed_in_s = ~op_i[0];
    assign shifted_s   = {rem_q[W-1:0], quo_q[W-1]};
    assign trial_s     = {rem_q[W], shifted_s} - {2'b00, dvs_q};
    assign keep_s      = ~trial_s[W+1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept_s ? S_CALC : S_IDLE;
            S_CALC:  state_d = (cnt_q == CNT_ONE) ? S_FIX : S_CALC;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = accept_s ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the upcoming state.
    always_comb begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        case (state_d)
            S_CALC:  busy_d  = 1'b1;
            S_FIX:   busy_d  = 1'b1;
            S_DONE:  valid_d = 1'b1;
            default: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Operand capture, restoring iteration and final result selection.
    always_comb begin
        rem_sel_d = rem_sel_q;
        a_d       = a_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    rem_sel_d = op_i[1];
                    a_d       = a_i;
                    dvs_d     = magnitude(b_i, signed_in_s);
                    rem_d     = {(W+1){1'b0}};
                    quo_d     = magnitude(a_i, signed_in_s);
                    cnt_d     = CNT_LOAD;
                    q_neg_d   = signed_in_s & (a_i[W-1] ^ b_i[W-1]);
                    r_neg_d   = signed_in_s & a_i[W-1];
                    dbz_d     = (b_i == ZERO);
                    ovf_d     = signed_in_s && (a_i == MOST_NEG) && (b_i == ALL_ONES);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_CALC: begin
                if (keep_s) begin
                    rem_d = trial_s[W:0];
                end else begin
                    rem_d = shifted_s;
                end
                quo_d = {quo_q[W-2:0], keep_s};
                cnt_d = cnt_q - CNT_ONE;
            end
            S_FIX: begin
                // Divide-by-zero returns the original dividend for rem, not its magnitude.
                if (dbz_q) begin
                    res_d = rem_sel_q ? a_q : ALL_ONES;
                end else if (ovf_q) begin
                    res_d = rem_sel_q ? ZERO : MOST_NEG;
                end else if (rem_sel_q) begin
                    res_d = r_neg_q ? negate(rem_q[W-1:0]) : rem_q[W-1:0];
                end else begin
                    res_d = q_neg_q ? negate(quo_q) : quo_q;
                end
            end
            default: begin
                res_d = res_q;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            res_q     <= {W{1'b0}};
            rem_sel_q <= 1'b0;
            a_q       <= {W{1'b0}};
            dvs_q     <= {W{1'b0}};
            rem_q     <= {(W+1){1'b0}};
            quo_q     <= {W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            res_q     <= res_d;
            rem_sel_q <= rem_sel_d;
            a_q       <= a_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign res_o   = res_q;

endmodule
